membus_router: RTL and testbench

MEMBUS_ROUTER -- requirements
Module: membus_router

---
 rtl/membus_router.sv | 176 +++++++++++++++++
 tb/tb_membus_router.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/membus_router.sv
// membus_router: routes single-outstanding CPU bus requests to one of NSLV
// address-decoded slave channels. It returns an error response, and records
// the failing address, for unmapped addresses and for slaves that stall
// past the timeout.
module membus_router #(
    parameter int unsigned        NSLV      = 4,
    parameter logic [32*NSLV-1:0] SLV_BASE  = '0,
    parameter logic [32*NSLV-1:0] SLV_MASK  = '0,
    parameter int unsigned        TIMEOUT   = 255,
    parameter logic [31:0]        ERR_RDATA = 32'hDEADBEEF
) (
    input  logic                 clock,
    input  logic                 resetn,

    // CPU side; m_wstrb == 0 means read
    input  logic                 m_valid,
    output logic                 m_ready,
    input  logic                 m_insn,
    input  logic [31:0]          m_addr,
    input  logic [31:0]          m_wdata,
    input  logic [3:0]           m_wstrb,
    output logic [31:0]          m_rdata,

    // slave side; address, write data and strobes are broadcast
    output logic [NSLV-1:0]      s_valid,
    input  logic [NSLV-1:0]      s_ready,
    output logic [31:0]          s_addr,
    output logic [31:0]          s_wdata,
    output logic [3:0]           s_wstrb,
    input  logic [32*NSLV-1:0]   s_rdata,

    // sticky error reporting
    output logic                 err_flag,
    output logic [31:0]          err_addr,
    input  logic                 err_clear
);

    localparam int unsigned SW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Count value seen in the last stalled ACTIVE cycle before expiry
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        RESP
    } state_t;

    state_t           state;
    logic [SW-1:0]    sel_q;
    logic [CW-1:0]    to_cnt;

    logic             dec_hit;
    logic [SW-1:0]    dec_sel;
    logic [NSLV-1:0]  dec_onehot;
    logic             sel_ready;
    logic [31:0]      sel_rdata;
    logic             timeout_hit;

    // m_insn is carried for debug visibility only and feeds no logic
    logic             insn_unused;
    assign insn_unused = m_insn;

    // Priority address decode: the lowest-index hitting window wins
    always_comb begin
        dec_hit    = 1'b0;
        dec_sel    = '0;
        dec_onehot = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (!dec_hit &&
                ((m_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
                dec_hit       = 1'b1;
                dec_sel       = SW'(i);
                dec_onehot[i] = 1'b1;
            end
        end
    end

    // Response mux: only the selected channel's ready and read data are seen
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (sel_q == SW'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[32*i +: 32];
            end
        end
    end

    // Expiry fires on the stalled cycle that makes the count reach TIMEOUT
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (to_cnt == TO_LAST);
    end

    // Transaction FSM with registered bus outputs and sticky error capture
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            sel_q    <= '0;
            to_cnt   <= '0;
            m_ready  <= 1'b0;
            m_rdata  <= '0;
            s_valid  <= '0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_wstrb  <= '0;
            err_flag <= 1'b0;
            err_addr <= '0;
        end else begin
            // A clear is overridden below when an error is raised in the same cycle
            if (err_clear) begin
                err_flag <= 1'b0;
            end

            case (state)
                IDLE: begin
                    m_ready <= 1'b0;
                    if (m_valid) begin
                        s_addr  <= m_addr;
                        s_wdata <= m_wdata;
                        s_wstrb <= m_wstrb;
                        sel_q   <= dec_sel;
                        to_cnt  <= '0;
                        if (dec_hit) begin
                            s_valid <= dec_onehot;
                            state   <= ACTIVE;
                        end else begin
                            m_ready  <= 1'b1;
                            m_rdata  <= ERR_RDATA;
                            err_flag <= 1'b1;
                            if (!err_flag || err_clear) begin
                                err_addr <= m_addr;
                            end
                            state    <= RESP;
                        end
                    end
                end

                ACTIVE: begin
                    // Slave data takes precedence over a simultaneous expiry
                    if (sel_ready) begin
                        s_valid <= '0;
                        m_ready <= 1'b1;
                        m_rdata <= sel_rdata;
                        state   <= RESP;
                    end else if (timeout_hit) begin
                        to_cnt   <= to_cnt + CW'(1);
                        s_valid  <= '0;
                        m_ready  <= 1'b1;
                        m_rdata  <= ERR_RDATA;
                        err_flag <= 1'b1;
                        if (!err_flag || err_clear) begin
                            err_addr <= s_addr;
                        end
                        state    <= RESP;
                    end else begin
                        to_cnt <= to_cnt + CW'(1);
                    end
                end

                RESP: begin
                    m_ready <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    m_ready <= 1'b0;
                    s_valid <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_membus_router.sv
// Testbench for membus_router: directed scenarios plus randomized traffic
// checked against a transaction-level reference model of the router.
`timescale 1ns/1ps
module tb_membus_router;

    localparam int          NS   = 3;
    localparam int          TMO  = 8;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;
    localparam logic [95:0] BASES = {32'h0100_0000, 32'h0001_0000, 32'h0000_0000};
    localparam logic [95:0] MASKS = {32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_FC00};

    logic        clock = 1'b0;
    logic        resetn;
    logic        m_valid, m_ready, m_insn;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [2:0]  s_valid, s_ready;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [95:0] s_rdata;
    logic        err_flag, err_clear;
    logic [31:0] err_addr;

    // second instance with overlapping windows: ch0 = 0x0000xxxx, ch1 = everything
    logic        m2_valid, m2_ready;
    logic [31:0] m2_addr, m2_rdata, s2_addr, s2_wdata, e2_addr;
    logic [3:0]  s2_wstrb;
    logic [1:0]  s2_valid, s2_ready;
    logic [63:0] s2_rdata;
    logic        e2_flag;

    always #5 clock = ~clock;

    membus_router #(
        .NSLV(NS), .SLV_BASE(BASES), .SLV_MASK(MASKS), .TIMEOUT(TMO), .ERR_RDATA(ERRD)
    ) dut (
        .clock(clock), .resetn(resetn),
        .m_valid(m_valid), .m_ready(m_ready), .m_insn(m_insn), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .err_flag(err_flag), .err_addr(err_addr), .err_clear(err_clear)
    );

    membus_router #(
        .NSLV(2), .SLV_BASE(64'h0), .SLV_MASK({32'h0000_0000, 32'hFFFF_0000}),
        .TIMEOUT(4), .ERR_RDATA(32'hBAD0_BAD0)
    ) dut2 (
        .clock(clock), .resetn(resetn),
        .m_valid(m2_valid), .m_ready(m2_ready), .m_insn(1'b0), .m_addr(m2_addr),
        .m_wdata(32'h0), .m_wstrb(4'h0), .m_rdata(m2_rdata),
        .s_valid(s2_valid), .s_ready(s2_ready), .s_addr(s2_addr), .s_wdata(s2_wdata),
        .s_wstrb(s2_wstrb), .s_rdata(s2_rdata),
        .err_flag(e2_flag), .err_addr(e2_addr), .err_clear(1'b0)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sdat [3];
    logic [31:0] win_base [3] = '{32'h0000_0000, 32'h0001_0000, 32'h0100_0000};
    logic [31:0] win_mask [3] = '{32'hFFFF_FC00, 32'hFFFF_0000, 32'hFF00_0000};
    bit          mdl_flag = 1'b0;
    logic [31:0] mdl_eaddr = '0;

    task automatic rand_sdat();
        for (int i = 0; i < 3; i++) sdat[i] = $urandom;
    endtask

    // Reference model: outcome of one transaction from the address map, slave wait and timeout rules
    task automatic mdl_txn(input logic [31:0] a, input int wait_n, input bit clr0,
                           output int e_cyc, output logic [31:0] e_rd,
                           output logic [2:0] e_sv, output int e_svcnt);
        int ch;
        bit err;
        ch = -1;
        for (int i = 0; i < 3; i++)
            if (ch < 0 && (a & win_mask[i]) == win_base[i]) ch = i;
        if (ch < 0) begin
            e_cyc = 1; e_rd = ERRD; e_sv = 3'b000; e_svcnt = 0; err = 1'b1;
        end else if (wait_n < TMO) begin
            e_cyc = wait_n + 2; e_rd = sdat[ch]; e_sv = 3'(1 << ch); e_svcnt = wait_n + 1; err = 1'b0;
        end else begin
            e_cyc = TMO + 1; e_rd = ERRD; e_sv = 3'(1 << ch); e_svcnt = TMO; err = 1'b1;
        end
        if (clr0) mdl_flag = 1'b0;
        if (err) begin
            if (!mdl_flag) mdl_eaddr = a;
            mdl_flag = 1'b1;
        end
    endtask

    // Bus driver: issues one request at the current negedge (cycle 0) and acts as the slaves
    task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input int wait_n, input bit chain, input bit clr0,
                          output int rdy_cyc, output logic [31:0] rd, output int sv_cnt,
                          output logic [2:0] sv_or, output int first_sv,
                          output bit stable_ok, output bit resp_ok);
        logic [2:0] noise;
        bit done;
        rdy_cyc = -1; rd = '0; sv_cnt = 0; sv_or = '0; first_sv = -1;
        stable_ok = 1'b1; resp_ok = 1'b1; done = 1'b0;
        s_rdata = {sdat[2], sdat[1], sdat[0]};
        m_valid = 1'b1; m_insn = 1'($urandom); m_addr = a; m_wdata = wd; m_wstrb = ws;
        err_clear = clr0;
        s_ready = 3'($urandom);
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clock);
            err_clear = 1'b0;
            if (m_ready) begin
                rdy_cyc = c; rd = m_rdata;
                if (s_valid !== 3'b000) resp_ok = 1'b0;
                m_valid = chain; s_ready = '0;
                @(negedge clock);
                if (m_ready !== 1'b0) resp_ok = 1'b0;
                m_valid = 1'b0;
                done = 1'b1;
            end else begin
                if (c == 1) begin
                    // the router must work from its own copies after acceptance
                    m_addr = $urandom; m_wdata = $urandom; m_wstrb = 4'($urandom);
                end
                if (s_valid != 3'b000) begin
                    sv_cnt++; sv_or |= s_valid;
                    if (first_sv < 0) first_sv = c;
                    if (s_addr !== a || s_wdata !== wd || s_wstrb !== ws) stable_ok = 1'b0;
                    noise = 3'($urandom);
                    s_ready = (noise & ~s_valid) | ((sv_cnt > wait_n) ? s_valid : 3'b000);
                end else begin
                    s_ready = 3'($urandom);
                end
            end
        end
        if (!done) begin
            m_valid = 1'b0; s_ready = '0;
        end
    endtask

    task automatic test_reset();
        checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL reset_m_ready got %b want 0", m_ready); end
        checks++; if (s_valid !== 3'b000) begin errors++; $display("FAIL reset_s_valid got %b want 000", s_valid); end
        checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL reset_m_rdata got %h want 0", m_rdata); end
        checks++; if ({err_flag, err_addr} !== 33'h0) begin errors++; $display("FAIL reset_err got %b/%h want 0/0", err_flag, err_addr); end
        checks++; if ({s_addr, s_wdata, s_wstrb} !== 68'h0) begin errors++; $display("FAIL reset_s_bus got %h %h %h want 0", s_addr, s_wdata, s_wstrb); end
    endtask

    task automatic test_read_zero_wait();
        int cyc, svc, fsv; logic [31:0] rd; logic [2:0] svo; bit st, rok;
        rand_sdat(); sdat[0] = 32'h1234_5678;
        do_txn(32'h0000_0010, 32'h0, 4'h0, 0, 1'b0, 1'b0, cyc, rd, svc, svo, fsv, st, rok);
        checks++; if (fsv !== 1 || svo !== 3'b001) begin errors++; $display("FAIL rd0_s_valid got cyc %0d sel %b want cyc 1 sel 001", fsv, svo); end
        checks++; if (cyc !== 2) begin errors++; $display("FAIL rd0_latency got %0d want 2", cyc); end
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL rd0_data got %h want 12345678", rd); end
        checks++; if (!rok || err_flag !== 1'b0) begin errors++; $display("FAIL rd0_resp got ok %b err %b want 1 0", rok, err_flag); end
    endtask

    task automatic test_write_waits();
        int cyc, svc, fsv; logic [31:0] rd; logic [2:0] svo; bit st, rok;
        rand_sdat();
        do_txn(32'h0001_0004, 32'hA5A5_A5A5, 4'b0011, 3, 1'b0, 1'b0, cyc, rd, svc, svo, fsv, st, rok);
        checks++; if (!st || svo !== 3'b010) begin errors++; $display("FAIL wr_stable got stable %b sel %b want 1 010", st, svo); end
        checks++; if (cyc !== 5 || svc !== 4) begin errors++; $display("FAIL wr_latency got %0d/%0d want 5/4", cyc, svc); end
        checks++; if (!rok || err_flag !== 1'b0) begin errors++; $display("FAIL wr_resp got ok %b err %b want 1 0", rok, err_flag); end
    endtask

    task automatic test_timeout();
        int cyc, svc, fsv; logic [31:0] rd; logic [2:0] svo; bit st, rok;
        rand_sdat();
        do_txn(32'h0100_0000, 32'h0, 4'h0, 1000, 1'b0, 1'b0, cyc, rd, svc, svo, fsv, st, rok);
        checks++; if (svc !== TMO || svo !== 3'b100) begin errors++; $display("FAIL to_s_valid got %0d cycles sel %b want 8 100", svc, svo); end
        checks++; if (cyc !== TMO + 1 || rd !== ERRD || !rok) begin errors++; $display("FAIL to_resp got cyc %0d data %h want 9 deadbeef", cyc, rd); end
        checks++; if (err_flag !== 1'b1 || err_addr !== 32'h0100_0000) begin errors++; $display("FAIL to_err got %b %h want 1 01000000", err_flag, err_addr); end
        // a second error must not overwrite the recorded address
        do_txn(32'h0080_0000, 32'h0, 4'h0, 0, 1'b0, 1'b0, cyc, rd, svc, svo, fsv, st, rok);
        checks++; if (err_addr !== 32'h0100_0000) begin errors++; $display("FAIL to_keep_addr got %h want 01000000", err_addr); end
        err_clear = 1'b1; @(negedge clock); err_clear = 1'b0;
        checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL to_clear got %b want 0", err_flag); end
    endtask

    task automatic test_unmapped();
        int cyc, svc, fsv; logic [31:0] rd; logic [2:0] svo; bit st, rok;
        rand_sdat();
        do_txn(32'h0080_0000, 32'h1111_2222, 4'hF, 0, 1'b0, 1'b0, cyc, rd, svc, svo, fsv, st, rok);
        checks++; if (svc !== 0 || cyc !== 1) begin errors++; $display("FAIL um_timing got sv %0d cyc %0d want 0 1", svc, cyc); end
        checks++; if (rd !== ERRD || !rok) begin errors++; $display("FAIL um_data got %h want deadbeef", rd); end
        checks++; if (err_flag !== 1'b1 || err_addr !== 32'h0080_0000) begin errors++; $display("FAIL um_err got %b %h want 1 00800000", err_flag, err_addr); end
        // clear and a new error in the same cycle: the error wins and reloads the address
        do_txn(32'h0090_0000, 32'h0, 4'h0, 0, 1'b0, 1'b1, cyc, rd, svc, svo, fsv, st, rok);
        checks++; if (err_flag !== 1'b1 || err_addr !== 32'h0090_0000) begin errors++; $display("FAIL um_clr_collide got %b %h want 1 00900000", err_flag, err_addr); end
        err_clear = 1'b1; @(negedge clock); err_clear = 1'b0;
    endtask

    task automatic test_timeout_boundary();
        int cyc, svc, fsv; logic [31:0] rd; logic [2:0] svo; bit st, rok;
        rand_sdat();
        // ready on the very cycle the count would expire
        do_txn(32'h0100_0040, 32'h0, 4'h0, TMO - 1, 1'b0, 1'b0, cyc, rd, svc, svo, fsv, st, rok);
        checks++; if (cyc !== TMO + 1 || rd !== sdat[2]) begin errors++; $display("FAIL tb_edge_data got cyc %0d %h want 9 %h", cyc, rd, sdat[2]); end
        checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL tb_edge_err got %b want 0", err_flag); end
    endtask

    task automatic test_reset_mid();
        int cyc, svc, fsv; logic [31:0] rd; logic [2:0] svo; bit st, rok, pulse;
        rand_sdat();
        s_rdata = {sdat[2], sdat[1], sdat[0]};
        m_valid = 1'b1; m_addr = 32'h0001_0020; m_wdata = 32'h0; m_wstrb = 4'h0; s_ready = '0;
        repeat (3) @(negedge clock);
        checks++; if (s_valid !== 3'b010) begin errors++; $display("FAIL rm_active got %b want 010", s_valid); end
        resetn = 1'b0; m_valid = 1'b0;
        #1;
        checks++; if (s_valid !== 3'b000 || m_ready !== 1'b0) begin errors++; $display("FAIL rm_async got %b %b want 000 0", s_valid, m_ready); end
        checks++; if (m_rdata !== 32'h0 || s_addr !== 32'h0) begin errors++; $display("FAIL rm_regs got %h %h want 0 0", m_rdata, s_addr); end
        @(negedge clock); resetn = 1'b1;
        mdl_flag = 1'b0; mdl_eaddr = '0;
        pulse = 1'b0;
        repeat (3) begin @(negedge clock); if (m_ready || s_valid != 0) pulse = 1'b1; end
        checks++; if (pulse) begin errors++; $display("FAIL rm_no_pulse got activity want none"); end
        do_txn(32'h0000_0000, 32'h0, 4'h0, 0, 1'b0, 1'b0, cyc, rd, svc, svo, fsv, st, rok);
        checks++; if (cyc !== 2 || rd !== sdat[0] || !rok) begin errors++; $display("FAIL rm_after got cyc %0d %h want 2 %h", cyc, rd, sdat[0]); end
    endtask

    task automatic test_back_to_back();
        int cyc, svc, fsv; logic [31:0] rd; logic [2:0] svo; bit st, rok;
        rand_sdat();
        do_txn(32'h0000_0010, 32'h0, 4'h0, 0, 1'b1, 1'b0, cyc, rd, svc, svo, fsv, st, rok);
        checks++; if (cyc !== 2 || rd !== sdat[0] || !rok) begin errors++; $display("FAIL b2b_first got cyc %0d %h want 2 %h", cyc, rd, sdat[0]); end
        do_txn(32'h0001_0008, 32'h0, 4'h0, 1, 1'b0, 1'b0, cyc, rd, svc, svo, fsv, st, rok);
        checks++; if (fsv !== 1 || svo !== 3'b010) begin errors++; $display("FAIL b2b_decode got cyc %0d sel %b want 1 010", fsv, svo); end
        checks++; if (cyc !== 3 || rd !== sdat[1] || !rok) begin errors++; $display("FAIL b2b_second got cyc %0d %h want 3 %h", cyc, rd, sdat[1]); end
    endtask

    task automatic test_priority();
        logic [31:0] addrs [2] = '{32'h0000_1234, 32'h0005_0000};
        logic [1:0]  want  [2] = '{2'b01, 2'b10};
        logic [31:0] d0, d1, rd, exp_rd;
        logic [1:0]  seen;
        int          cyc;
        for (int k = 0; k < 2; k++) begin
            d0 = $urandom; d1 = $urandom; s2_rdata = {d1, d0}; s2_ready = 2'b11;
            m2_addr = addrs[k]; m2_valid = 1'b1; seen = '0; cyc = -1; rd = '0;
            for (int c = 1; c <= 10 && cyc < 0; c++) begin
                @(negedge clock);
                seen |= s2_valid;
                if (m2_ready) begin cyc = c; rd = m2_rdata; m2_valid = 1'b0; end
            end
            @(negedge clock);
            exp_rd = (k == 0) ? d0 : d1;
            checks++; if (seen !== want[k]) begin errors++; $display("FAIL prio_sel got %b want %b", seen, want[k]); end
            checks++; if (rd !== exp_rd || cyc !== 2) begin errors++; $display("FAIL prio_data got %h cyc %0d want %h 2", rd, cyc, exp_rd); end
        end
    endtask

    task automatic test_random();
        int cyc, svc, fsv, e_cyc, e_svc, w, cls;
        logic [31:0] a, rd, e_rd;
        logic [2:0] svo, e_sv;
        bit st, rok, ch, clr;
        for (int n = 0; n < 40; n++) begin
            cls = $urandom_range(0, 4);
            case (cls)
                0: a = {22'h0, 10'($urandom)};
                1: a = {16'h0001, 16'($urandom)};
                2: a = {8'h01, 24'($urandom)};
                3: a = $urandom;
                default: a = 32'h0000_0400 | {16'h0, 16'($urandom)};
            endcase
            w = $urandom_range(0, 9);
            ch = ($urandom_range(0, 1) == 1);
            clr = ($urandom_range(0, 5) == 0);
            rand_sdat();
            mdl_txn(a, w, clr, e_cyc, e_rd, e_sv, e_svc);
            do_txn(a, $urandom, 4'($urandom), w, ch, clr, cyc, rd, svc, svo, fsv, st, rok);
            checks++; if (cyc !== e_cyc || svc !== e_svc) begin errors++; $display("FAIL rnd_timing a=%h got %0d/%0d want %0d/%0d", a, cyc, svc, e_cyc, e_svc); end
            checks++; if (rd !== e_rd) begin errors++; $display("FAIL rnd_data a=%h got %h want %h", a, rd, e_rd); end
            checks++; if (svo !== e_sv || !st || !rok) begin errors++; $display("FAIL rnd_slave a=%h got sel %b stable %b resp %b want %b 1 1", a, svo, st, rok, e_sv); end
            checks++; if (err_flag !== mdl_flag || err_addr !== mdl_eaddr) begin errors++; $display("FAIL rnd_err a=%h got %b %h want %b %h", a, err_flag, err_addr, mdl_flag, mdl_eaddr); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the test sequence completed");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; m_valid = 1'b0; m_insn = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s_ready = '0; s_rdata = '0; err_clear = 1'b0;
        m2_valid = 1'b0; m2_addr = '0; s2_ready = '0; s2_rdata = '0;
        #1;
        test_reset();
        @(negedge clock); resetn = 1'b1;
        @(negedge clock);
        test_read_zero_wait();
        test_write_waits();
        test_timeout();
        test_unmapped();
        test_timeout_boundary();
        test_reset_mid();
        test_back_to_back();
        test_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
